// File: rtl/fm_sb_playback_if.sv
// fm_sb_playback_if
//   Bundles the two buses of the spy-buffer playback reader:
//   - RAM read port: mem_rd_en / mem_addr out of the reader, mem_rd_data back
//     one cycle after each strobe.
//   - Replay stream: pb_data / pb_valid out of the reader, pb_ready back from
//     the downstream datapath.
//   Modports:
//     master - the playback reader (drives strobe, address and stream)
//     slave  - the RAM / downstream side (drives read data and ready)
interface fm_sb_playback_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] pb_data;
    logic                  pb_valid;
    logic                  pb_ready;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        output pb_data,
        output pb_valid,
        input  pb_ready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        input  pb_data,
        input  pb_valid,
        output pb_ready
    );
endinterface

// File: rtl/fm_sb_playback.sv
// fm_sb_playback
//   Replays a latched address window of a frozen spy-buffer RAM onto the
//   high-speed datapath, once (single-shot) or repeatedly (loop).
//   Ports:
//     clk_hs, rst_hs       datapath clock, asynchronous active-low reset
//     freeze               spy buffer frozen, RAM contents stable
//     playback_mode        0 off, 1 single-shot, 2 loop, others treated as off
//     start_addr/end_addr  window bounds (inclusive), may wrap through 0
//     bus (master)         RAM read port and valid/ready replay stream
//     pb_active            reader in RUN or DRAIN
//     pb_done              single-shot pass completed and drained
//     pb_loop_count        completed loop passes, saturating
module fm_sb_playback #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned PB_MODE_WIDTH = 2
) (
    input  logic                     clk_hs,
    input  logic                     rst_hs,
    input  logic                     freeze,
    input  logic [PB_MODE_WIDTH-1:0] playback_mode,
    input  logic [ADDR_WIDTH-1:0]    start_addr,
    input  logic [ADDR_WIDTH-1:0]    end_addr,
    fm_sb_playback_if.master         bus,
    output logic                     pb_active,
    output logic                     pb_done,
    output logic [15:0]              pb_loop_count
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [PB_MODE_WIDTH-1:0] mode_q, mode_cur;
    logic                     loop_q, loop_d;
    logic [ADDR_WIDTH-1:0]    start_q, start_d;
    logic [ADDR_WIDTH-1:0]    end_q, end_d;
    logic [ADDR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic                     inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0]    fifo_q [2];
    logic [DATA_WIDTH-1:0]    fifo_d [2];
    logic                     wr_idx_q, wr_idx_d;
    logic                     rd_idx_q, rd_idx_d;
    logic [1:0]               fifo_cnt_q, fifo_cnt_d;
    logic [15:0]              loop_cnt_q, loop_cnt_d;

    logic       pop;
    logic       rd_en;
    logic       abort;
    logic [1:0] occ;

    // Only modes 1 and 2 are meaningful; everything else behaves as off.
    assign mode_cur = (playback_mode == PB_MODE_WIDTH'(1) || playback_mode == PB_MODE_WIDTH'(2))
                      ? playback_mode : '0;

    assign pop   = (fifo_cnt_q != 2'd0) && bus.pb_ready;
    // Words already owned (buffered or in flight) after this cycle's pop; a new read may only
    // be issued if the FIFO is still guaranteed a slot when its data comes back.
    assign occ   = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign rd_en = (state_q == StRun) && (occ < 2'd2);
    assign abort = ((state_q == StRun) || (state_q == StDrain)) &&
                   (!freeze || (mode_cur == '0));

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = rd_ptr_q;
    assign bus.pb_data   = fifo_q[rd_idx_q];
    assign bus.pb_valid  = (fifo_cnt_q != 2'd0);
    assign pb_active     = (state_q == StRun) || (state_q == StDrain);
    assign pb_done       = (state_q == StDone);
    assign pb_loop_count = loop_cnt_q;

    always_comb begin
        state_d    = state_q;
        loop_d     = loop_q;
        start_d    = start_q;
        end_d      = end_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = rd_en;
        fifo_d     = fifo_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        fifo_cnt_d = fifo_cnt_q;
        loop_cnt_d = loop_cnt_q;

        // Output FIFO; read data is pushed in the cycle it is valid on the RAM port.
        if (abort) begin
            inflight_d = 1'b0;
            fifo_cnt_d = 2'd0;
            wr_idx_d   = 1'b0;
            rd_idx_d   = 1'b0;
        end else begin
            if (inflight_q) begin
                fifo_d[wr_idx_q] = bus.mem_rd_data;
                wr_idx_d         = ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_d = ~rd_idx_q;
            end
            fifo_cnt_d = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        end

        case (state_q)
            StIdle: begin
                // Start needs a fresh 0 -> 1/2 transition seen while frozen.
                if ((mode_q == '0) && (mode_cur != '0) && freeze) begin
                    start_d    = start_addr;
                    end_d      = end_addr;
                    loop_d     = (mode_cur == PB_MODE_WIDTH'(2));
                    loop_cnt_d = 16'd0;
                    rd_ptr_d   = start_addr;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (rd_en) begin
                    if (rd_ptr_q == end_q) begin
                        if (loop_q) begin
                            rd_ptr_d = start_q;
                            if (loop_cnt_q != 16'hffff) begin
                                loop_cnt_d = loop_cnt_q + 16'd1;
                            end
                        end else begin
                            state_d = StDrain;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            StDrain: begin
                // Looking at next-state occupancy lets pb_done follow the final pop directly.
                if (abort) begin
                    state_d = StIdle;
                end else if ((fifo_cnt_d == 2'd0) && !inflight_d) begin
                    state_d = StDone;
                end
            end
            default: begin
                if (mode_q == '0) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_hs or negedge rst_hs) begin
        if (!rst_hs) begin
            state_q    <= StIdle;
            mode_q     <= '0;
            loop_q     <= 1'b0;
            start_q    <= '0;
            end_q      <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_idx_q   <= 1'b0;
            rd_idx_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            loop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_cur;
            loop_q     <= loop_d;
            start_q    <= start_d;
            end_q      <= end_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            fifo_cnt_q <= fifo_cnt_d;
            loop_cnt_q <= loop_cnt_d;
        end
    end

endmodule

// File: tb/tb_fm_sb_playback.sv
// Bench for fm_sb_playback: a RAM model answers reads, expected words are queued when a window is
// started and popped as the DUT hands words over.
module tb_fm_sb_playback;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 10;

    logic          clk_hs = 1'b0;
    logic          rst_hs = 1'b0;
    logic          freeze = 1'b0;
    logic [1:0]    playback_mode = 2'd0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic          pb_active;
    logic          pb_done;
    logic [15:0]   pb_loop_count;

    fm_sb_playback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fm_sb_playback #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .PB_MODE_WIDTH(2)
    ) dut (
        .clk_hs(clk_hs),
        .rst_hs(rst_hs),
        .freeze(freeze),
        .playback_mode(playback_mode),
        .start_addr(start_addr),
        .end_addr(end_addr),
        .bus(bus),
        .pb_active(pb_active),
        .pb_done(pb_done),
        .pb_loop_count(pb_loop_count)
    );

    always #5 clk_hs = ~clk_hs;

    int n_checks = 0;
    int n_errors = 0;
    int held = 0;
    int held_max = 0;
    int rd_total = 0;
    bit bp_chk = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] exp_q[$];

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {16'hbeef, 6'd0, a, 22'd0, a};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM model: data is valid the cycle after the read strobe.
    always @(posedge clk_hs) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= word_of(bus.mem_addr);
    end

    // Scoreboard / stream monitor.
    always @(negedge clk_hs) begin
        if (rst_hs) begin
            logic popped;
            logic [DW-1:0] exp;
            popped = bus.pb_valid && bus.pb_ready;
            if (bp_chk && prev_valid && !prev_ready) begin
                check_eq("hold_valid", bus.pb_valid, 1'b1);
                check_eq("hold_data", bus.pb_data, prev_data);
            end
            if (popped) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_extra_word", exp_q.size(), 1);
                end else begin
                    exp = exp_q.pop_front();
                    check_eq("sb_data", bus.pb_data, exp);
                end
            end
            if (bus.mem_rd_en) rd_total++;
            held = held + int'(bus.mem_rd_en) - int'(popped);
            if (held > held_max) held_max = held;
            prev_valid = bus.pb_valid;
            prev_ready = bus.pb_ready;
            prev_data  = bus.pb_data;
        end
    end

    task automatic step();
        @(posedge clk_hs);
        #1;
    endtask

    task automatic push_window(input logic [AW-1:0] s, input logic [AW-1:0] e);
        logic [AW-1:0] a;
        a = s;
        exp_q.push_back(word_of(a));
        while (a != e) begin
            a = a + 1'b1;
            exp_q.push_back(word_of(a));
        end
    endtask

    task automatic start_run(input logic [AW-1:0] s, input logic [AW-1:0] e,
                             input logic [1:0] m);
        start_addr    = s;
        end_addr      = e;
        freeze        = 1'b1;
        playback_mode = m;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk_hs);
            if (pb_done) break;
        end
        check_eq("done_seen", pb_done, 1'b1);
        check_eq("sb_drained", exp_q.size(), 0);
        check_eq("done_loop_cnt", pb_loop_count, 16'd0);
    endtask

    task automatic clear_mode();
        step();
        playback_mode = 2'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_hs);
            if (!pb_done) break;
        end
        check_eq("done_clear", pb_done, 1'b0);
    endtask

    initial begin
        int n;
        bus.pb_ready = 1'b1;

        // Reset values.
        @(negedge clk_hs);
        check_eq("rst_rd_en", bus.mem_rd_en, 1'b0);
        check_eq("rst_addr", bus.mem_addr, '0);
        check_eq("rst_valid", bus.pb_valid, 1'b0);
        check_eq("rst_data", bus.pb_data, '0);
        check_eq("rst_active", pb_active, 1'b0);
        check_eq("rst_done", pb_done, 1'b0);
        check_eq("rst_loop_cnt", pb_loop_count, 16'd0);
        step();
        rst_hs = 1'b1;

        // Single-shot 4..7, latency and done timing.
        push_window(10'd4, 10'd7);
        step();
        start_run(10'd4, 10'd7, 2'd1);
        step();
        @(negedge clk_hs);
        check_eq("t1_rd_en", bus.mem_rd_en, 1'b1);
        check_eq("t1_addr", bus.mem_addr, 10'd4);
        check_eq("t1_active", pb_active, 1'b1);
        check_eq("t1_valid", bus.pb_valid, 1'b0);
        step();
        @(negedge clk_hs);
        check_eq("t2_valid", bus.pb_valid, 1'b0);
        step();
        @(negedge clk_hs);
        check_eq("t3_valid", bus.pb_valid, 1'b1);
        repeat (3) step();
        @(negedge clk_hs);
        check_eq("t6_done", pb_done, 1'b0);
        check_eq("t6_active", pb_active, 1'b1);
        step();
        @(negedge clk_hs);
        check_eq("t7_done", pb_done, 1'b1);
        check_eq("t7_active", pb_active, 1'b0);
        check_eq("t7_drained", exp_q.size(), 0);
        clear_mode();

        // Wrapped window 1022..1.
        push_window(10'd1022, 10'd1);
        step();
        start_run(10'd1022, 10'd1, 2'd1);
        wait_done(40);
        clear_mode();

        // Backpressure 1,0,0,1 on window 0..9.
        push_window(10'd0, 10'd9);
        step();
        held = 0;
        held_max = 0;
        bp_chk = 1'b1;
        start_run(10'd0, 10'd9, 2'd1);
        for (int i = 0; i < 200; i++) begin
            step();
            bus.pb_ready = (i % 4 == 0) || (i % 4 == 3);
            @(negedge clk_hs);
            if (pb_done) break;
        end
        wait_done(4);
        check_eq("max_buffered", held_max, 2);
        bp_chk = 1'b0;
        bus.pb_ready = 1'b1;
        clear_mode();

        // Loop 0..2: ten words, then abort by mode -> 0.
        for (int p = 0; p < 3; p++) push_window(10'd0, 10'd2);
        exp_q.push_back(word_of(10'd0));
        step();
        start_run(10'd0, 10'd2, 2'd2);
        repeat (12) step();
        playback_mode = 2'd0;
        @(negedge clk_hs);
        check_eq("loop_cnt_at_10", pb_loop_count, 16'd3);
        check_eq("loop_valid_at_10", bus.pb_valid, 1'b1);
        step();
        @(negedge clk_hs);
        check_eq("loop_abort_valid", bus.pb_valid, 1'b0);
        check_eq("loop_abort_rd_en", bus.mem_rd_en, 1'b0);
        check_eq("loop_abort_active", pb_active, 1'b0);
        check_eq("loop_done", pb_done, 1'b0);
        check_eq("loop_cnt_hold", pb_loop_count, 16'd3);
        check_eq("loop_drained", exp_q.size(), 0);

        // Abort by freeze with the FIFO full, then restart.
        bus.pb_ready = 1'b0;
        step();
        start_run(10'd0, 10'd9, 2'd1);
        repeat (4) step();
        @(negedge clk_hs);
        check_eq("full_valid", bus.pb_valid, 1'b1);
        check_eq("full_rd_en", bus.mem_rd_en, 1'b0);
        check_eq("full_head", bus.pb_data, word_of(10'd0));
        step();
        freeze = 1'b0;
        @(negedge clk_hs);
        check_eq("pre_abort_valid", bus.pb_valid, 1'b1);
        step();
        @(negedge clk_hs);
        check_eq("abort_valid", bus.pb_valid, 1'b0);
        check_eq("abort_rd_en", bus.mem_rd_en, 1'b0);
        check_eq("abort_active", pb_active, 1'b0);
        check_eq("abort_done", pb_done, 1'b0);
        step();
        playback_mode = 2'd0;
        freeze = 1'b1;
        bus.pb_ready = 1'b1;
        push_window(10'd0, 10'd9);
        step();
        start_run(10'd0, 10'd9, 2'd1);
        wait_done(40);
        clear_mode();

        // No start without freeze, and no start on freeze alone once mode is already set.
        step();
        freeze = 1'b0;
        playback_mode = 2'd1;
        n = rd_total;
        repeat (6) step();
        @(negedge clk_hs);
        check_eq("nofreeze_reads", rd_total - n, 0);
        check_eq("nofreeze_active", pb_active, 1'b0);
        step();
        freeze = 1'b1;
        repeat (4) step();
        @(negedge clk_hs);
        check_eq("stale_mode_reads", rd_total - n, 0);
        step();
        playback_mode = 2'd0;

        // Asynchronous reset mid-run.
        push_window(10'd0, 10'd9);
        step();
        start_run(10'd0, 10'd9, 2'd1);
        repeat (5) step();
        #1;
        rst_hs = 1'b0;
        #1;
        check_eq("arst_rd_en", bus.mem_rd_en, 1'b0);
        check_eq("arst_addr", bus.mem_addr, '0);
        check_eq("arst_valid", bus.pb_valid, 1'b0);
        check_eq("arst_data", bus.pb_data, '0);
        check_eq("arst_active", pb_active, 1'b0);
        check_eq("arst_done", pb_done, 1'b0);
        exp_q.delete();
        playback_mode = 2'd0;
        step();
        rst_hs = 1'b1;
        repeat (3) step();
        @(negedge clk_hs);
        check_eq("post_rst_active", pb_active, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", n_checks,
                 n_errors);
        $fatal(1, "timeout");
    end
endmodule
